fmul_iter: RTL and testbench

FMUL_ITER -- requirements
Module: fmul_iter

---
 rtl/fmul_iter.sv | 233 +++++++++++++++++++++++
 tb/tb_fmul_iter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fmul_iter.sv
// rtl/fmul_iter.sv - iterative radix-2 IEEE-754 single multiplier; optional early-out for special operands under FMUL_EARLY_OUT_EN
module fmul_iter (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  rm,
  input  logic        fmul,
  input  logic        ena,
  output logic [31:0] s,
  output logic        busy,
  output logic        stall,
  output logic [4:0]  count,
  output logic        valid
);

  typedef enum logic [1:0] {IDLE, ITER, NORM, DONE} state_t;

  state_t state_q, state_d;

  logic [4:0]        count_q;
  logic              sign_q;
  logic [1:0]        rm_q;
  logic              zero_a_q, zero_b_q, inf_a_q, inf_b_q, nan_a_q, nan_b_q;
  logic [23:0]       ma_q, mb_q;
  logic signed [9:0] exp_q;
  logic [47:0]       prod_q;
  logic [31:0]       s_q;

  // Shift that brings the highest set bit of v up to bit 23 (0 for v == 0).
  function automatic logic [4:0] lead_shift(input logic [23:0] v);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < 24; i++) begin
      if (v[i]) n = 5'(23 - i);
    end
    return n;
  endfunction

  // {hit, result} for operands whose product is decided without the datapath.
  function automatic logic [32:0] special_of(input logic za, input logic zb,
                                             input logic ia, input logic ib,
                                             input logic na, input logic nb,
                                             input logic sg);
    if (na | nb | (ia & zb) | (ib & za)) return {1'b1, sg, 31'h7fc00000};
    else if (ia | ib)                    return {1'b1, sg, 31'h7f800000};
    else if (za | zb)                    return {1'b1, sg, 31'h00000000};
    else                                 return 33'd0;
  endfunction

  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        zero_a_d, zero_b_d, inf_a_d, inf_b_d, nan_a_d, nan_b_d, den_a, den_b;
  logic [23:0] raw_a, raw_b, ma_d, mb_d;
  logic [4:0]  sha, shb;
  logic [9:0]  exp_d;
  logic        accept, early;

  assign ea = a[30:23];
  assign eb = b[30:23];
  assign fa = a[22:0];
  assign fb = b[22:0];

  assign zero_a_d = (ea == 8'd0) && (fa == 23'd0);
  assign zero_b_d = (eb == 8'd0) && (fb == 23'd0);
  assign inf_a_d  = (ea == 8'hff) && (fa == 23'd0);
  assign inf_b_d  = (eb == 8'hff) && (fb == 23'd0);
  assign nan_a_d  = (ea == 8'hff) && (fa != 23'd0);
  assign nan_b_d  = (eb == 8'hff) && (fb != 23'd0);
  assign den_a    = (ea == 8'd0) && (fa != 23'd0);
  assign den_b    = (eb == 8'd0) && (fb != 23'd0);

  // Denormals carry a zero exponent field and are renormalized here so the
  // iteration always works on 1.xxx significands.
  assign raw_a = den_a ? {fa, 1'b0} : {1'b1, fa};
  assign raw_b = den_b ? {fb, 1'b0} : {1'b1, fb};
  assign sha   = den_a ? lead_shift(raw_a) : 5'd0;
  assign shb   = den_b ? lead_shift(raw_b) : 5'd0;
  assign ma_d  = raw_a << sha;
  assign mb_d  = raw_b << shb;
  assign exp_d = {2'b00, ea} + {2'b00, eb} - 10'd127 - {5'd0, sha} - {5'd0, shb};

  // DONE also accepts, so back-to-back operations start one edge after the strobe.
  assign accept = ena & fmul & ((state_q == IDLE) | (state_q == DONE));

`ifdef FMUL_EARLY_OUT_EN
  logic [32:0] spec_in;
  assign spec_in = special_of(zero_a_d, zero_b_d, inf_a_d, inf_b_d, nan_a_d, nan_b_d, a[31] ^ b[31]);
  assign early   = spec_in[32];
`else
  assign early   = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode and status outputs.
  always_comb begin
    state_d = state_q;
    busy    = (state_q != IDLE);
    valid   = (state_q == DONE);
    stall   = fmul & busy;
    if (ena) begin
      case (state_q)
        IDLE, DONE: state_d = accept ? (early ? DONE : ITER) : IDLE;
        ITER:       if (count_q == 5'd23) state_d = NORM;
        NORM:       state_d = DONE;
        default:    state_d = IDLE;
      endcase
    end
  end

  // Operand capture at acceptance, then one shift-add step per enabled ITER cycle.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      count_q  <= 5'd0;
      sign_q   <= 1'b0;
      rm_q     <= 2'b00;
      zero_a_q <= 1'b0;
      zero_b_q <= 1'b0;
      inf_a_q  <= 1'b0;
      inf_b_q  <= 1'b0;
      nan_a_q  <= 1'b0;
      nan_b_q  <= 1'b0;
      ma_q     <= 24'd0;
      mb_q     <= 24'd0;
      exp_q    <= '0;
      prod_q   <= 48'd0;
    end else if (ena) begin
      if (accept) begin
        count_q  <= 5'd0;
        sign_q   <= a[31] ^ b[31];
        rm_q     <= rm;
        zero_a_q <= zero_a_d;
        zero_b_q <= zero_b_d;
        inf_a_q  <= inf_a_d;
        inf_b_q  <= inf_b_d;
        nan_a_q  <= nan_a_d;
        nan_b_q  <= nan_b_d;
        ma_q     <= ma_d;
        mb_q     <= mb_d;
        exp_q    <= exp_d;
        prod_q   <= 48'd0;
      end else if (state_q == ITER) begin
        if (mb_q[count_q]) prod_q <= prod_q + ({24'd0, ma_q} << count_q);
        count_q <= (count_q == 5'd23) ? 5'd0 : count_q + 5'd1;
      end
    end
  end

  logic              r_n, st_n, r_d, st_d, inc, ovf, to_inf;
  logic [23:0]       m_n, m_d, m_f;
  logic [24:0]       m_r;
  logic signed [9:0] e_n, e_d, e_f;
  logic [9:0]        sh;
  logic [49:0]       wide;
  logic [30:0]       mag;
  logic [32:0]       spec_reg;
  logic [31:0]       norm_s;

  // Normalize, denormalize with sticky, round and pack the product.
  always_comb begin
    m_n  = prod_q[46:23];
    r_n  = prod_q[22];
    st_n = |prod_q[21:0];
    e_n  = exp_q;
    if (prod_q[47]) begin
      m_n  = prod_q[47:24];
      r_n  = prod_q[23];
      st_n = |prod_q[22:0];
      e_n  = exp_q + 10'sd1;
    end

    sh   = 10'd0;
    wide = '0;
    m_d  = m_n;
    r_d  = r_n;
    st_d = st_n;
    e_d  = e_n;
    if (e_n <= 10'sd0) begin
      sh  = 10'd1 - $unsigned(e_n);
      e_d = 10'sd1;
      if (sh > 10'd25) begin
        m_d  = 24'd0;
        r_d  = 1'b0;
        st_d = (|m_n) | r_n | st_n;
      end else begin
        wide = {m_n, r_n, 25'd0} >> sh;
        m_d  = wide[49:26];
        r_d  = wide[25];
        st_d = st_n | (|wide[24:0]);
      end
    end

    case (rm_q)
      2'b00:   inc = r_d & (st_d | m_d[0]);
      2'b01:   inc = sign_q & (r_d | st_d);
      2'b10:   inc = ~sign_q & (r_d | st_d);
      default: inc = 1'b0;
    endcase

    m_r = {1'b0, m_d} + {24'd0, inc};
    m_f = m_r[24] ? 24'h800000 : m_r[23:0];
    e_f = m_r[24] ? e_d + 10'sd1 : e_d;

    ovf    = (e_f >= 10'sd255);
    to_inf = (rm_q == 2'b00) | ((rm_q == 2'b01) & sign_q) | ((rm_q == 2'b10) & ~sign_q);
    if (ovf) mag = to_inf ? 31'h7f800000 : 31'h7f7fffff;
    else     mag = {(m_f[23] ? e_f[7:0] : 8'd0), m_f[22:0]};

    spec_reg = special_of(zero_a_q, zero_b_q, inf_a_q, inf_b_q, nan_a_q, nan_b_q, sign_q);
    norm_s   = spec_reg[32] ? spec_reg[31:0] : {sign_q, mag};
  end

  // Result register, loaded only on entry to DONE.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      s_q <= 32'd0;
    end else if (ena) begin
      if (state_q == NORM) s_q <= norm_s;
`ifdef FMUL_EARLY_OUT_EN
      else if (accept && spec_in[32]) s_q <= spec_in[31:0];
`endif
    end
  end

  assign s     = s_q;
  assign count = count_q;

endmodule

// File: tb/tb_fmul_iter.sv
// tb/tb_fmul_iter.sv - self-checking bench for fmul_iter against a value-level IEEE-754 product model
module tb_fmul_iter;

  logic        clk = 1'b0;
  logic        clr, fmul, ena;
  logic [31:0] a, b;
  logic [1:0]  rm;
  logic [31:0] s;
  logic        busy, stall, valid;
  logic [4:0]  count;

  int checks   = 0;
  int failures = 0;

`ifdef FMUL_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  fmul_iter dut (
    .clk(clk), .clr(clr), .a(a), .b(b), .rm(rm), .fmul(fmul), .ena(ena),
    .s(s), .busy(busy), .stall(stall), .count(count), .valid(valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit is_special(input logic [31:0] x, input logic [31:0] y);
    return (x[30:23] == 8'hff) || (y[30:23] == 8'hff) || (x[30:0] == 31'd0) || (y[30:0] == 31'd0);
  endfunction

  // Exact product as integer * 2^exponent, then one IEEE rounding to single.
  function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y, input logic [1:0] mode);
    logic sg, xn, yn, xi, yi, xz, yz, above, tie, inexact, up;
    longint unsigned mx, my, p, q, rem, half;
    int ex, ey, e, msb, lsb_e, sh, bexp;
    sg = x[31] ^ y[31];
    xn = (x[30:23] == 8'hff) && (x[22:0] != 0);
    yn = (y[30:23] == 8'hff) && (y[22:0] != 0);
    xi = (x[30:23] == 8'hff) && (x[22:0] == 0);
    yi = (y[30:23] == 8'hff) && (y[22:0] == 0);
    xz = (x[30:0] == 0);
    yz = (y[30:0] == 0);
    if (xn || yn || (xi && yz) || (yi && xz)) return {sg, 31'h7fc00000};
    if (xi || yi) return {sg, 31'h7f800000};
    if (xz || yz) return {sg, 31'h00000000};
    mx = (x[30:23] == 0) ? longint'(x[22:0]) : longint'({1'b1, x[22:0]});
    my = (y[30:23] == 0) ? longint'(y[22:0]) : longint'({1'b1, y[22:0]});
    ex = (x[30:23] == 0) ? -149 : int'(x[30:23]) - 150;
    ey = (y[30:23] == 0) ? -149 : int'(y[30:23]) - 150;
    p = mx * my;
    e = ex + ey;
    msb = 0;
    for (int i = 0; i < 64; i++) if (p[i]) msb = i;
    lsb_e = msb + e - 23;
    if (lsb_e < -149) lsb_e = -149;
    sh = lsb_e - e;
    if (sh <= 0) begin
      q = p << (-sh); above = 0; tie = 0; inexact = 0;
    end else if (sh >= 62) begin
      q = 0; above = 0; tie = 0; inexact = 1;
    end else begin
      q = p >> sh;
      rem = p & ((64'd1 << sh) - 1);
      half = 64'd1 << (sh - 1);
      above = rem > half;
      tie = rem == half;
      inexact = rem != 0;
    end
    case (mode)
      2'd0:    up = above || (tie && q[0]);
      2'd1:    up = sg && inexact;
      2'd2:    up = !sg && inexact;
      default: up = 0;
    endcase
    q = q + longint'(up);
    if (q == (64'd1 << 24)) begin
      q = 64'd1 << 23;
      lsb_e++;
    end
    if (q < (64'd1 << 23)) return {sg, 8'd0, q[22:0]};
    bexp = lsb_e + 150;
    if (bexp >= 255)
      return (mode == 2'd0 || (mode == 2'd1 && sg) || (mode == 2'd2 && !sg)) ? {sg, 31'h7f800000} : {sg, 31'h7f7fffff};
    return {sg, bexp[7:0], q[22:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] v;
    int k;
    v = $urandom;
    k = $urandom_range(0, 9);
    case (k)
      0:       v[30:23] = 8'd0;
      1:       v[30:0]  = 31'd0;
      2:       v[30:23] = 8'hff;
      3:       v[30:23] = 8'($urandom_range(1, 10));
      4:       v[30:23] = 8'($urandom_range(240, 254));
      5:       v[30:23] = 8'($urandom_range(55, 70));
      default: v[30:23] = 8'($urandom_range(100, 154));
    endcase
    return v;
  endfunction

  // Issue one op from IDLE/DONE; returns result, edges from E0 to valid, and busy-held flag.
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic [1:0] mode,
                        output logic [31:0] res, output int lat, output bit busy_ok);
    a = x; b = y; rm = mode; fmul = 1'b1;
    @(posedge clk); #1;
    fmul = 1'b0;
    lat = 0;
    busy_ok = busy;
    while (!valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (!busy) busy_ok = 1'b0;
    end
    res = s;
  endtask

  task automatic op_check(input string tag, input logic [31:0] x, input logic [31:0] y, input logic [1:0] mode);
    logic [31:0] res;
    int lat;
    bit bok;
    run_op(x, y, mode, res, lat, bok);
    chk({tag, "_s"}, res, ref_mul(x, y, mode));
    chk({tag, "_lat"}, lat, (EARLY && is_special(x, y)) ? 0 : 25);
  endtask

  logic [31:0] res, r1, r2, x1, y1, x2, y2, s_hold;
  int lat;
  bit bok, flag, vseen;

  initial begin
    clr = 1'b1; ena = 1'b1; fmul = 1'b1; a = 32'h3f800000; b = 32'h3f800000; rm = 2'b00;
    #1;
    chk("rst_s", s, 32'd0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_count", count, 0);
    chk("rst_stall", stall, 0);
    repeat (2) @(posedge clk);
    #1; fmul = 1'b0; clr = 1'b0;

    run_op(32'h3fc00000, 32'h40000000, 2'b00, res, lat, bok);
    chk("basic_s", res, 32'h40400000);
    chk("basic_lat", lat, 25);
    chk("basic_busy", bok, 1);
    @(posedge clk); #1;
    chk("basic_valid_once", valid, 0);
    chk("basic_idle", busy, 0);

    op_check("ovf_rne", 32'h7f000000, 32'h40000000, 2'b00);
    op_check("ovf_rtz", 32'h7f000000, 32'h40000000, 2'b11);
    op_check("ovf_neg_rdn", 32'hff000000, 32'h40000000, 2'b01);
    op_check("inf_zero", 32'h7f800000, 32'h00000000, 2'b00);
    op_check("tie_rne", 32'h00000001, 32'h3f000000, 2'b00);
    op_check("tie_rup", 32'h00000001, 32'h3f000000, 2'b10);
    op_check("min_norm", 32'h00800000, 32'h3f800000, 2'b00);
    chk("const_ovf", ref_mul(32'h7f000000, 32'h40000000, 2'b11), 32'h7f7fffff);
    chk("const_tie", ref_mul(32'h00000001, 32'h3f000000, 2'b10), 32'h00000001);

    // Back-to-back with fmul held: second op waits through DONE.
    x1 = 32'h40490fdb; y1 = 32'hc0000000; x2 = 32'h3e800000; y2 = 32'h41200001;
    a = x1; b = y1; rm = 2'b00; fmul = 1'b1;
    @(posedge clk); #1;
    a = x2; b = y2;
    flag = 1'b1; vseen = 1'b0;
    for (int i = 0; i <= 25; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      if (stall !== 1'b1) flag = 1'b0;
      if (i < 25 && valid) vseen = 1'b1;
      if (i == 10) chk("b2b_count10", count, 10);
    end
    chk("b2b_stall", flag, 1);
    chk("b2b_no_early_valid", vseen, 0);
    chk("b2b_valid1", valid, 1);
    chk("b2b_s1", s, ref_mul(x1, y1, 2'b00));
    @(posedge clk); #1;
    fmul = 1'b0;
    chk("b2b_accept2", busy & ~valid, 1);
    lat = 0;
    while (!valid && lat < 200) begin @(posedge clk); #1; lat++; end
    chk("b2b_lat2", lat, 25);
    chk("b2b_s2", s, ref_mul(x2, y2, 2'b00));

    // Abort mid-iteration with clr.
    a = 32'h3fc00000; b = 32'h40400000; rm = 2'b00; fmul = 1'b1;
    @(posedge clk); #1;
    fmul = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    chk("clr_pre_count", count, 10);
    clr = 1'b1; #1;
    chk("clr_busy", busy, 0);
    chk("clr_s", s, 0);
    chk("clr_count", count, 0);
    chk("clr_valid", valid, 0);
    @(posedge clk); #1;
    clr = 1'b0;
    vseen = 1'b0;
    repeat (20) begin @(posedge clk); #1; if (valid) vseen = 1'b1; end
    chk("clr_no_valid", vseen, 0);
    op_check("clr_after", 32'h3fc00000, 32'h40400000, 2'b00);

    // ena low freezes iteration and a pending DONE.
    a = 32'h3f9e0652; b = 32'h40b33333; rm = 2'b10; fmul = 1'b1;
    @(posedge clk); #1;
    fmul = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    ena = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("frz_count", count, 5);
    ena = 1'b1;
    lat = 0;
    while (!valid && lat < 200) begin @(posedge clk); #1; lat++; end
    chk("frz_lat", lat, 20);
    chk("frz_s", s, ref_mul(32'h3f9e0652, 32'h40b33333, 2'b10));
    s_hold = s;
    ena = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("frz_done_valid", valid, 1);
    chk("frz_done_s", s, s_hold);
    ena = 1'b1;
    @(posedge clk); #1;
    chk("frz_release", valid, 0);

    for (int n = 0; n < 40; n++) begin
      x1 = rand_op();
      y1 = rand_op();
      op_check($sformatf("rnd%0d", n), x1, y1, 2'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
